// File: rtl/alu_dispatch_unit.sv
// alu_dispatch_unit: accepts one ALU op per handshake, decodes its class
// field into a one-hot unit enable, and holds that enable until the selected
// unit reports done or the watchdog expires.
// Also flags illegal class codes and counts completed ops.
module alu_dispatch_unit #(
    parameter int FUN_W     = 4,
    parameter int CLASS_W   = 2,
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 15,
    parameter int CNT_W     = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [FUN_W-1:0]         alu_fun,
    output logic [NUM_UNITS-1:0]     unit_en,
    output logic [FUN_W-CLASS_W-1:0] unit_sub,
    input  logic [NUM_UNITS-1:0]     unit_done,
    output logic                     res_valid,
    output logic [CLASS_W-1:0]       res_unit,
    output logic                     illegal_op,
    output logic                     timeout,
    output logic [CNT_W-1:0]         op_count
);

    localparam int SUB_W = FUN_W - CLASS_W;
    // One spare bit keeps the watchdog at least 2 bits wide even for TIMEOUT=1.
    localparam int WD_W  = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Class index -> one-hot unit enable.
    function automatic logic [NUM_UNITS-1:0] class_onehot(input logic [CLASS_W-1:0] cls);
        logic [NUM_UNITS-1:0] oh;
        oh = {NUM_UNITS{1'b0}};
        for (int i = 0; i < NUM_UNITS; i++) begin
            oh[i] = (cls == CLASS_W'(i));
        end
        return oh;
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [CLASS_W-1:0]     class_r, class_nxt_s;
    logic [WD_W-1:0]        wd_r, wd_nxt_s;
    logic [NUM_UNITS-1:0]   unit_en_nxt_s;
    logic [SUB_W-1:0]       unit_sub_nxt_s;
    logic                   res_valid_nxt_s;
    logic [CLASS_W-1:0]     res_unit_nxt_s;
    logic                   illegal_nxt_s;
    logic                   timeout_nxt_s;
    logic [CNT_W-1:0]       op_count_nxt_s;

    logic [CLASS_W-1:0]     class_s;
    logic [SUB_W-1:0]       sub_s;
    logic [31:0]            class_ext_s;
    logic                   legal_s;
    logic                   done_sel_s;
    logic                   wd_expired_s;

    assign class_s      = alu_fun[FUN_W-1 -: CLASS_W];
    assign sub_s        = alu_fun[SUB_W-1:0];
    assign class_ext_s  = 32'(class_s);
    assign legal_s      = (class_ext_s < 32'(NUM_UNITS));
    // unit_en is one-hot on the captured class, so masking picks exactly that unit's done.
    assign done_sel_s   = |(unit_done & unit_en);
    assign wd_expired_s = (wd_r == WD_W'(TIMEOUT - 1));
    assign op_ready     = (state_r == IDLE);

    // Next-state and next-output decode; done takes priority over the watchdog.
    always_comb begin
        state_nxt_s     = state_r;
        class_nxt_s     = class_r;
        wd_nxt_s        = wd_r;
        unit_en_nxt_s   = unit_en;
        unit_sub_nxt_s  = unit_sub;
        res_valid_nxt_s = 1'b0;
        res_unit_nxt_s  = res_unit;
        illegal_nxt_s   = 1'b0;
        timeout_nxt_s   = 1'b0;
        op_count_nxt_s  = op_count;
        case (state_r)
            IDLE: begin
                if (op_valid) begin
                    if (legal_s) begin
                        state_nxt_s    = BUSY;
                        unit_en_nxt_s  = class_onehot(class_s);
                        unit_sub_nxt_s = sub_s;
                        class_nxt_s    = class_s;
                        wd_nxt_s       = {WD_W{1'b0}};
                    end else begin
                        illegal_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (done_sel_s) begin
                    state_nxt_s     = IDLE;
                    unit_en_nxt_s   = {NUM_UNITS{1'b0}};
                    res_valid_nxt_s = 1'b1;
                    res_unit_nxt_s  = class_r;
                    op_count_nxt_s  = op_count + CNT_W'(1'b1);
                end else if (wd_expired_s) begin
                    state_nxt_s     = IDLE;
                    unit_en_nxt_s   = {NUM_UNITS{1'b0}};
                    timeout_nxt_s   = 1'b1;
                end else begin
                    wd_nxt_s        = wd_r + WD_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                unit_en_nxt_s = {NUM_UNITS{1'b0}};
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; reset aborts any op without a pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            class_r    <= {CLASS_W{1'b0}};
            wd_r       <= {WD_W{1'b0}};
            unit_en    <= {NUM_UNITS{1'b0}};
            unit_sub   <= {SUB_W{1'b0}};
            res_valid  <= 1'b0;
            res_unit   <= {CLASS_W{1'b0}};
            illegal_op <= 1'b0;
            timeout    <= 1'b0;
            op_count   <= {CNT_W{1'b0}};
        end else begin
            class_r    <= class_nxt_s;
            wd_r       <= wd_nxt_s;
            unit_en    <= unit_en_nxt_s;
            unit_sub   <= unit_sub_nxt_s;
            res_valid  <= res_valid_nxt_s;
            res_unit   <= res_unit_nxt_s;
            illegal_op <= illegal_nxt_s;
            timeout    <= timeout_nxt_s;
            op_count   <= op_count_nxt_s;
        end
    end

endmodule

// File: doc/alu_dispatch_unit.md
Name: alu_dispatch_unit

Overview:
- Parametrised, registered successor to the ALU function decoder.
- Accepts one ALU op per handshake and decodes its class field into a one-hot unit enable.
- Holds the enable until the selected unit signals done, then reports completion.
- Sits between the ALU top-level control and the arithmetic, logic, compare and shift units. Adds illegal-code detection, a timeout watchdog and a completed-op counter.

Parameters:
- FUN_W, 4: width of alu_fun.
- CLASS_W, 2: upper alu_fun bits selecting the unit class.
- NUM_UNITS, 4: number of execution units. Legal range is 1..2**CLASS_W.
- TIMEOUT, 15: maximum BUSY cycles to wait for unit_done. Must be ≥1.
- CNT_W, 8: width of the completed-op counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- op_valid  input  1  op request.
- op_ready  output  1  dispatcher can accept an op.
- alu_fun  input  FUN_W  function code; class = alu_fun[FUN_W-1 -: CLASS_W], sub = remaining low bits.
- unit_en  output  NUM_UNITS  one-hot enable; bit i = class i (0 arith, 1 logic, 2 compare, 3 shift).
- unit_sub  output  FUN_W-CLASS_W  registered sub-function for the enabled unit.
- unit_done  input  NUM_UNITS  per-unit completion strobe.
- res_valid  output  1  one-cycle pulse when an op completes.
- res_unit  output  CLASS_W  class index of the completed op; valid with res_valid.
- illegal_op  output  1  one-cycle pulse for an accepted op with class ≥ NUM_UNITS.
- timeout  output  1  one-cycle pulse when a unit fails to complete.
- op_count  output  CNT_W  completed-op counter; wraps modulo 2**CNT_W.

Behaviour:

Reset values:
- RST=1 at a rising edge forces state=IDLE and clears all registers.
- unit_en=0, unit_sub=0, res_valid=0, res_unit=0, illegal_op=0, timeout=0, op_count=0, op_ready=1 (after reset).
- Reset mid-operation aborts the op silently: no res_valid and no timeout pulse.

States:
- IDLE, BUSY. op_ready = (state==IDLE), driven combinationally from the state register.

IDLE:
- Accept on op_valid & op_ready.
- Legal class (class < NUM_UNITS):
  - next cycle: state=BUSY, unit_en=1<<class, unit_sub=sub, captured class stored, watchdog counter=0.
- Illegal class:
  - next cycle: illegal_op=1 for one cycle, unit_en stays 0, state stays IDLE, op_ready stays 1.
  - op_count is not incremented.
- op_valid=0: nothing changes.
- alu_fun is don't-care unless op_valid is high.

BUSY:
- op_ready=0. unit_en and unit_sub are held stable; alu_fun changes are ignored.
- Each cycle, check unit_done[captured class]; all other unit_done bits are ignored.
- If done is set:
  - next cycle: state=IDLE, unit_en=0, res_valid=1, res_unit=captured class.
  - op_count increments in that same next cycle.
- Otherwise the watchdog increments.
- If the watchdog reaches TIMEOUT-1 with no done:
  - next cycle: state=IDLE, unit_en=0, timeout=1 for one cycle, no res_valid, op_count unchanged.
- If done and the timeout condition occur in the same cycle, done wins.

Latency and throughput:
- Accept edge → unit_en high 1 cycle later.
- A unit that asserts done in its first enabled cycle produces res_valid 2 cycles after accept.
- op_ready returns high in the same cycle as res_valid, so the next op can be accepted there.
- Minimum spacing is 2 cycles per op.

Invariants:
- unit_en is always zero or one-hot.
- res_valid, illegal_op and timeout are mutually exclusive in any cycle.

Wrap-around:
- op_count rolls over from 2**CNT_W-1 to 0 with no flag.

Test Plan:
- Reset/idle: RST=1 for 2 cycles then released → all outputs 0, op_ready=1, op_count=0.
- Arith op, combinational unit:
  - stimulus: alu_fun=4'b0011 accepted; unit_done[0]=1 whenever unit_en[0]=1.
  - required: unit_en=4'b0001 and unit_sub=2'b11 one cycle after accept; res_valid=1 with res_unit=0 two cycles after accept; op_count=1.
- Shift op, slow unit:
  - stimulus: alu_fun=4'b1101; unit_done[3] asserted on the 5th BUSY cycle; op_valid held high throughout.
  - required: unit_en=4'b1000 for exactly 5 cycles; op_ready=0 for those cycles; res_unit=3.
  - required: wrong-unit done (unit_done[1]=1 during BUSY) ignored; back-to-back op accepted in the res_valid cycle.
- Timeout:
  - stimulus: TIMEOUT=4, compare op alu_fun=4'b1000, unit_done never asserted.
  - required: unit_en=4'b0100 for 4 cycles; then timeout pulse, no res_valid, op_count unchanged, op_ready=1.
  - variant: done in the 4th cycle → res_valid, no timeout.
- Illegal code:
  - stimulus: NUM_UNITS=3, alu_fun=4'b1110.
  - required: illegal_op=1 for one cycle, unit_en stays 0, op_ready stays 1; next legal op dispatches normally.
- Reset mid-op and counter wrap:
  - stimulus: RST during BUSY.
  - required: unit_en=0 next cycle, no res_valid or timeout pulse, op_count=0.
  - stimulus: CNT_W=2 with 5 completed ops → op_count sequence 1,2,3,0,1.
